// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier with valid/ready handshakes on both sides.
// Signed operands are reduced to magnitudes at capture and the product is sign-corrected at the end.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [PW-1:0]   mcand_r;
  logic [PW-1:0]   acc_r;
  logic [PW-1:0]   acc_sum_s;
  logic [WIDTH-1:0] mplier_r;
  logic            neg_r;
  logic            accept_s;
  logic            last_s;

  // The most negative value maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = ~v + WIDTH'(1);
    end else begin
      magnitude = v;
    end
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST_ITER) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      BUSY: busy = 1'b1;
      DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Partial-product adder and control qualifiers.
  always_comb begin
    accept_s = in_valid && (state_r == IDLE);
    last_s   = (state_r == BUSY) && (cnt_r == LAST_ITER);
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
  end

  // Operand capture, one shift-add iteration per cycle, and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      acc_r    <= {PW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      neg_r    <= 1'b0;
      p        <= {PW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
            mplier_r <= magnitude(b, signed_mode);
            neg_r    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        BUSY: begin
          acc_r    <= acc_sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            p <= neg_r ? (~acc_sum_s + PW'(1)) : acc_sum_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=8 directed vectors and a WIDTH=4 random back-pressure run,
// both checked every cycle against a transaction-level reference model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        iv8 = 1'b0, ordy8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00;
  logic        ir8, ov8, bz8;
  logic [15:0] p8;

  logic        iv4 = 1'b0, ordy4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = 4'h0, b4 = 4'h0;
  logic        ir4, ov4, bz4;
  logic [7:0]  p4;

  int nchk = 0;
  int nerr = 0;
  int hs4  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) u_mul8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(ordy8), .p(p8), .busy(bz8)
  );

  seq_multiplier #(.WIDTH(4)) u_mul4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(ordy4), .p(p4), .busy(bz4)
  );

  // Per-instance views so the model and compare loop treat both DUTs alike.
  logic        iv_s[2], ordy_s[2], sm_s[2], ir_s[2], ov_s[2], bz_s[2];
  logic [7:0]  a_s[2], b_s[2];
  logic [15:0] dp_s[2];
  assign iv_s[0] = iv8;   assign iv_s[1] = iv4;
  assign ordy_s[0] = ordy8; assign ordy_s[1] = ordy4;
  assign sm_s[0] = sm8;   assign sm_s[1] = sm4;
  assign a_s[0] = a8;     assign a_s[1] = {4'h0, a4};
  assign b_s[0] = b8;     assign b_s[1] = {4'h0, b4};
  assign ir_s[0] = ir8;   assign ir_s[1] = ir4;
  assign ov_s[0] = ov8;   assign ov_s[1] = ov4;
  assign bz_s[0] = bz8;   assign bz_s[1] = bz4;
  assign dp_s[0] = p8;    assign dp_s[1] = {8'h00, p4};

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  // Reference product: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [15:0] ref_prod(input int w, input logic [7:0] x, input logic [7:0] y,
                                           input logic sm);
    longint xv, yv, pr;
    xv = longint'(x);
    yv = longint'(y);
    if (sm && x[w-1]) xv = xv - (longint'(1) << w);
    if (sm && y[w-1]) yv = yv - (longint'(1) << w);
    pr = xv * yv;
    pr = pr & ((longint'(1) << (2 * w)) - 1);
    return pr[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Transaction model: idle until accept, result due WIDTH edges later, held until taken.
  logic        m_idle[2], m_valid[2];
  logic [15:0] m_p[2], m_pend[2];
  int          m_due[2];
  int          cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int k = 0; k < 2; k++) begin
        m_idle[k]  <= 1'b1;
        m_valid[k] <= 1'b0;
        m_p[k]     <= 16'h0000;
        m_pend[k]  <= 16'h0000;
        m_due[k]   <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        if (m_idle[k]) begin
          if (iv_s[k]) begin
            m_idle[k] <= 1'b0;
            m_due[k]  <= cyc + wid(k);
            m_pend[k] <= ref_prod(wid(k), a_s[k], b_s[k], sm_s[k]);
          end
        end else if (m_valid[k]) begin
          if (ordy_s[k]) begin
            m_valid[k] <= 1'b0;
            m_idle[k]  <= 1'b1;
          end
        end else if (cyc == m_due[k]) begin
          m_valid[k] <= 1'b1;
          m_p[k]     <= m_pend[k];
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k),  32'(ir_s[k]), 32'(m_idle[k]));
      chk($sformatf("busy[%0d]", k),      32'(bz_s[k]), 32'(!m_idle[k]));
      chk($sformatf("out_valid[%0d]", k), 32'(ov_s[k]), 32'(m_valid[k]));
      chk($sformatf("p[%0d]", k),         32'(dp_s[k]), 32'(m_p[k]));
    end
  end

  always @(posedge clk) begin
    if (rst_n && ov4 && ordy4) hs4 <= hs4 + 1;
  end

  // Issue one WIDTH=8 operation now, then check latency, literal product, stall and release.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                      input logic [15:0] exp, input int stall, input string nm);
    int n;
    a8 = x; b8 = y; sm8 = sm; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; a8 = ~x; b8 = y ^ 8'h5A; sm8 = ~sm;
    n = 0;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd8);
    chk({nm, " p"}, 32'(p8), 32'(exp));
    repeat (stall) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
      chk({nm, " stall p"}, 32'(p8), 32'(exp));
      chk({nm, " stall valid"}, 32'(ov8), 32'd1);
      chk({nm, " stall in_ready"}, 32'(ir8), 32'd0);
    end
    iv8 = 1'b0;
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    chk({nm, " held p"}, 32'(p8), 32'(exp));
    chk({nm, " valid drop"}, 32'(ov8), 32'd0);
  endtask

  initial begin
    int n;
    int guard;
    logic rdy, accepted;

    #1 rst_n = 1'b0;
    #3;
    chk("reset in_ready", 32'(ir8), 32'd1);
    chk("reset out_valid", 32'(ov8), 32'd0);
    chk("reset busy", 32'(bz8), 32'd0);
    chk("reset p", 32'(p8), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, "u255x255");
    run8(8'h80, 8'hFF, 1'b1, 16'h0080, 0, "s-128x-1");
    run8(8'h80, 8'h80, 1'b1, 16'h4000, 0, "s-128x-128");
    run8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, "s-3x5");
    run8(8'hFD, 8'h05, 1'b0, 16'h04F1, 5, "u253x5_stall");

    // Reset in the middle of an operation, then a fresh operation.
    a8 = 8'd100; b8 = 8'd3; sm8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("midrst out_valid", 32'(ov8), 32'd0);
    chk("midrst p", 32'(p8), 32'd0);
    chk("midrst in_ready", 32'(ir8), 32'd1);
    #1 rst_n = 1'b1;
    run8(8'd7, 8'd6, 1'b0, 16'd42, 0, "u7x6");

    // WIDTH=4 random operands with random back-pressure.
    for (int t = 0; t < 40; t++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom_range(0, 1)); iv4 = 1'b1;
      guard = 0;
      accepted = 1'b0;
      while (!accepted && guard < 100) begin
        rdy = ir4;
        ordy4 = 1'($urandom_range(0, 1));
        @(negedge clk);
        accepted = rdy;
        guard++;
      end
      chk("w4 accept bound", 32'(accepted), 32'd1);
      iv4 = 1'b0;
      a4 = ~a4;
      b4 = ~b4;
    end
    ordy4 = 1'b1;
    n = 0;
    while (bz4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w4 drain bound", 32'(bz4), 32'd0);
    ordy4 = 1'b0;
    @(negedge clk);
    chk("w4 transactions", 32'(hs4), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operands and mode are presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  product is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the product.
REQ-011 SHALL have port p  output  2*WIDTH  product.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM (IDLE, BUSY, DONE) with a radix-2 shift-add datapath that processes one multiplier bit per clock.
REQ-014 SHALL drive in_ready = 1 only in IDLE.
REQ-015 SHALL accept an operand set on an edge where in_valid && in_ready, capturing a, b and signed_mode into internal registers, then move IDLE -> BUSY.
REQ-016 SHALL ignore a, b and signed_mode after capture; input changes during BUSY or DONE SHALL NOT affect the result.
REQ-017 SHALL, in signed mode, convert each operand to its magnitude at capture and negate the final product when the operand signs differ.
REQ-018 SHALL treat the most negative operand (-2^(WIDTH-1)) correctly, with magnitude 2^(WIDTH-1) held in WIDTH unsigned bits.
REQ-019 SHALL, in BUSY, use an iteration counter (clog2(WIDTH+1) bits) that runs WIDTH iterations, adding the shifted multiplicand magnitude to the accumulator when the current multiplier bit is 1.
REQ-020 SHALL, on the edge completing the WIDTH-th iteration, load p with the final (sign-corrected) 2*WIDTH-bit product and move BUSY -> DONE.
REQ-021 SHALL assert out_valid exactly WIDTH cycles after the accepting edge, and only in DONE.
REQ-022 SHALL hold p and out_valid stable in DONE until out_valid && out_ready, then move DONE -> IDLE and deassert out_valid on that same edge.
REQ-023 SHALL produce an exact result: p equals a*b, unsigned or two's-complement, with no overflow possible in 2*WIDTH bits.
REQ-024 SHALL hold the last product on p after the handshake, until the next completion or reset.
REQ-025 SHALL take an earliest back-to-back issue period of WIDTH+2 cycles (accept, WIDTH iterations, handshake edge, accept again in IDLE).
REQ-026 SHALL NOT allow in_ready and out_valid to be high in the same cycle.
REQ-027 SHALL treat out_ready as don't-care outside DONE.
REQ-028 SHALL treat in_valid as don't-care outside IDLE; no operand is queued.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force state IDLE, in_ready = 1, out_valid = 0, busy = 0, p = 0, and clear the counter and accumulator.
REQ-030 SHALL, when reset is asserted mid-operation (BUSY or DONE), discard the in-flight product with no out_valid pulse.
REQ-031 SHALL allow the block to accept operands on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL pass: WIDTH=8, unsigned, a=255, b=255 -> out_valid after 8 cycles, p=16'hFE01.
REQ-033 SHALL pass: WIDTH=8, signed, a=8'h80 (-128), b=8'hFF (-1) -> p=16'h0080 (+128); and a=8'h80, b=8'h80 -> p=16'h4000.
REQ-034 SHALL pass: WIDTH=8, signed, a=8'hFD (-3), b=8'h05 -> p=16'hFFF1 (-15); the same operands unsigned -> p=16'h04F1 (1265).
REQ-035 SHALL pass: out_ready held 0 for 5 cycles in DONE while a and b toggle -> p and out_valid stable, in_ready=0, no new accept.
REQ-036 SHALL pass: rst_n pulsed low at iteration 4 of BUSY -> out_valid stays 0, p=0, in_ready=1 after release, and the next operation (a=7, b=6 unsigned) yields p=42.
REQ-037 SHALL pass: WIDTH=4, random signed and unsigned operands with random out_ready back-pressure -> every p matches the reference product and no accepted transaction is lost or duplicated.
